// File: rtl/tt_chk_pkg.sv
// tt_chk_pkg: shared FSM state type, default thresholds and uio_out bit map for the count checker
package tt_chk_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

    localparam int DEF_LOCK_MATCHES = 4;
    localparam int DEF_LOSS_ERRORS  = 3;

    localparam int UIO_LOCKED = 2;
    localparam int UIO_LOSS   = 3;
    localparam int UIO_ERR    = 4;
    localparam int UIO_HUNT   = 5;

    localparam logic [7:0] UIO_OE_MASK = 8'b1111_1100;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/chk_sync2.sv
// chk_sync2: parameterised-width two-flop synchronizer with asynchronous active-low reset
module chk_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // two back-to-back capture stages; the second stage feeds the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/tt_um_count_checker.sv
// tt_um_count_checker: locks onto an incrementing 8-bit counter stream and counts mismatches.
// Define CHK_INPUT_SYNC_EN to route ui_in/valid/clear through a 2-flop synchronizer (+2 cycles).
module tt_um_count_checker
    import tt_chk_pkg::*;
#(
    parameter int LOCK_MATCHES = DEF_LOCK_MATCHES,
    parameter int LOSS_ERRORS  = DEF_LOSS_ERRORS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_MATCHES);
    localparam logic [3:0] LOSS_N = 4'(LOSS_ERRORS);

    logic [7:0] data;
    logic       valid;
    logic       clr;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:2]};

`ifdef CHK_INPUT_SYNC_EN
    chk_sync2 #(.W(10)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({uio_in[1:0], ui_in}),
        .q     ({clr, valid, data})
    );
`else
    assign data  = ui_in;
    assign valid = uio_in[0];
    assign clr   = uio_in[1];
`endif

    chk_state_e state_q, state_d;
    logic [7:0] expected_q, expected_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [3:0] err_run_q, err_run_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       loss_q, loss_d;
    logic       pulse_q, pulse_d;
    logic       locked_q;
    logic       hunting_q;

    // next-state: act on valid samples only; clear overrides any count/loss update this cycle
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        err_run_d   = err_run_q;
        err_cnt_d   = err_cnt_q;
        loss_d      = loss_q;
        pulse_d     = 1'b0;
        if (valid) begin
            case (state_q)
                HUNT: begin
                    expected_d  = data + 8'd1;
                    match_cnt_d = 4'd1;
                    state_d     = CONFIRM;
                end
                CONFIRM: begin
                    expected_d = data + 8'd1;
                    if (data == expected_q) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LOCK_N) begin
                            state_d   = LOCKED;
                            err_run_d = 4'd0;
                        end
                    end else begin
                        match_cnt_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (data == expected_q) begin
                        expected_d = data + 8'd1;
                        err_run_d  = 4'd0;
                    end else begin
                        expected_d = expected_q + 8'd1;
                        err_cnt_d  = sat_inc8(err_cnt_q);
                        err_run_d  = err_run_q + 4'd1;
                        pulse_d    = 1'b1;
                        if (err_run_q + 4'd1 == LOSS_N) begin
                            state_d = HUNT;
                            loss_d  = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (clr) begin
            err_cnt_d = 8'd0;
            loss_d    = 1'b0;
        end
    end

    // state and registered status flags, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            expected_q  <= 8'd0;
            match_cnt_q <= 4'd0;
            err_run_q   <= 4'd0;
            err_cnt_q   <= 8'd0;
            loss_q      <= 1'b0;
            pulse_q     <= 1'b0;
            locked_q    <= 1'b0;
            hunting_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            err_run_q   <= err_run_d;
            err_cnt_q   <= err_cnt_d;
            loss_q      <= loss_d;
            pulse_q     <= pulse_d;
            locked_q    <= (state_d == LOCKED);
            hunting_q   <= (state_d == HUNT);
        end
    end

    assign uo_out = err_cnt_q;
    assign uio_oe = UIO_OE_MASK;

    // pack status flags into their uio_out lanes, other lanes held low
    always_comb begin
        uio_out             = 8'h00;
        uio_out[UIO_LOCKED] = locked_q;
        uio_out[UIO_LOSS]   = loss_q;
        uio_out[UIO_ERR]    = pulse_q;
        uio_out[UIO_HUNT]   = hunting_q;
    end

endmodule

// File: tb/tb_tt_um_count_checker.sv
// tb_tt_um_count_checker: vector table, corner sequences and random stream against a reference model
module tb_tt_um_count_checker;

`ifdef CHK_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_count_checker #(.LOCK_MATCHES(LOCK), .LOSS_ERRORS(LOSS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (1'b1),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // reference model: stream-level rules, fed through a delay line matching input latency
    typedef struct {bit v; bit c; logic [7:0] d;} in_t;
    in_t pipe[$];
    bit m_locked, m_loss, m_pulse;
    int m_seen, m_next, m_miss, m_err;

    task automatic model_reset();
        in_t z;
        z.v = 0; z.c = 0; z.d = 8'h00;
        m_locked = 0; m_loss = 0; m_pulse = 0;
        m_seen = 0; m_next = 0; m_miss = 0; m_err = 0;
        pipe.delete();
        for (int i = 0; i < LAT; i++) pipe.push_back(z);
    endtask

    task automatic model_step(input bit v, input bit c, input int d);
        m_pulse = 0;
        if (v) begin
            if (m_locked) begin
                if (d == m_next) begin
                    m_miss = 0;
                    m_next = (d + 1) % 256;
                end else begin
                    m_pulse = 1;
                    m_err = (m_err >= 255) ? 255 : m_err + 1;
                    m_miss++;
                    m_next = (m_next + 1) % 256;
                    if (m_miss >= LOSS) begin
                        m_locked = 0;
                        m_seen = 0;
                        m_loss = 1;
                    end
                end
            end else if (m_seen > 0 && d == m_next) begin
                m_seen++;
                m_next = (d + 1) % 256;
                if (m_seen >= LOCK) begin
                    m_locked = 1;
                    m_miss = 0;
                end
            end else begin
                m_seen = 1;
                m_next = (d + 1) % 256;
            end
        end
        if (c) begin
            m_err = 0;
            m_loss = 0;
        end
    endtask

    task automatic cyc(input bit v, input bit c, input logic [7:0] d);
        in_t x;
        @(negedge clk);
        ui_in = d;
        uio_in = {6'b0, c, v};
        @(posedge clk);
        x.v = v; x.c = c; x.d = d;
        pipe.push_back(x);
        if (pipe.size() > LAT) begin
            x = pipe.pop_front();
            model_step(x.v, x.c, int'(x.d));
        end
        #1;
    endtask

    // one sample followed by enough idle cycles for it to reach the outputs
    task automatic send(input bit v, input bit c, input logic [7:0] d);
        cyc(v, c, d);
        repeat (LAT) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h00;
        uio_in = 8'h00;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all(input string nm);
        chk({nm, " err_cnt"}, int'(uo_out), m_err);
        chk({nm, " locked"}, int'(uio_out[2]), int'(m_locked));
        chk({nm, " hunting"}, int'(uio_out[5]), int'(!m_locked && m_seen == 0));
        chk({nm, " loss"}, int'(uio_out[3]), int'(m_loss));
        chk({nm, " pulse"}, int'(uio_out[4]), int'(m_pulse));
        chk({nm, " pad"}, int'(uio_out & 8'hC3), 0);
    endtask

    typedef struct {
        bit rst; bit v; bit c; logic [7:0] d;
        bit lk; bit hu; bit ls; bit pu; logic [7:0] er;
    } row_t;
    row_t tbl[$];

    function automatic row_t r(bit rst, bit v, bit c, logic [7:0] d,
                               bit lk, bit hu, bit ls, bit pu, logic [7:0] er);
        row_t x;
        x.rst = rst; x.v = v; x.c = c; x.d = d;
        x.lk = lk; x.hu = hu; x.ls = ls; x.pu = pu; x.er = er;
        return x;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        logic [7:0] ctr;
        bit v, c;

        // lock on 10..13, a valid=0 gap in between never disturbs anything
        tbl.push_back(r(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h10, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h11, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 0, 0, 8'hAA, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h12, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h13, 1, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h14, 1, 0, 0, 0, 8'h00));
        // FF -> 00 wrap is a match
        tbl.push_back(r(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'hFA, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'hFB, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'hFC, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'hFD, 1, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'hFE, 1, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'hFF, 1, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h01, 1, 0, 0, 0, 8'h00));
        // single glitch realigns, then three misses lose lock, then clear
        tbl.push_back(r(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h1D, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h1E, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h1F, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h20, 1, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h21, 1, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h55, 1, 0, 0, 1, 8'h01));
        tbl.push_back(r(0, 1, 0, 8'h23, 1, 0, 0, 0, 8'h01));
        tbl.push_back(r(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h02));
        tbl.push_back(r(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h03));
        tbl.push_back(r(0, 1, 0, 8'h00, 0, 1, 1, 1, 8'h04));
        tbl.push_back(r(0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00));
        // mismatch during confirm re-seeds without counting; clear beats a loss event
        tbl.push_back(r(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h40, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h41, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h99, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h9A, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h9B, 0, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h9C, 1, 0, 0, 0, 8'h00));
        tbl.push_back(r(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h01));
        tbl.push_back(r(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h02));
        tbl.push_back(r(0, 1, 1, 8'h00, 0, 1, 0, 1, 8'h00));

        model_reset();
        chk("oe", int'(uio_oe), 8'hFC);
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            else send(tbl[i].v, tbl[i].c, tbl[i].d);
            chk($sformatf("row%0d err_cnt", i), int'(uo_out), int'(tbl[i].er));
            chk($sformatf("row%0d locked", i), int'(uio_out[2]), int'(tbl[i].lk));
            chk($sformatf("row%0d hunting", i), int'(uio_out[5]), int'(tbl[i].hu));
            chk($sformatf("row%0d loss", i), int'(uio_out[3]), int'(tbl[i].ls));
            chk($sformatf("row%0d pulse", i), int'(uio_out[4]), int'(tbl[i].pu));
        end

        // 300 mismatches over repeated lock/loss cycles saturate the counter
        do_reset();
        repeat (100) begin
            for (int k = 0; k < LOCK; k++) send(1, 0, 8'h10 + 8'(k));
            e = 8'h10 + 8'(LOCK);
            repeat (LOSS) begin
                send(1, 0, e ^ 8'h80);
                e = e + 8'd1;
            end
        end
        chk("sat err_cnt", int'(uo_out), 8'hFF);
        check_all("sat");
        for (int k = 0; k < LOCK; k++) send(1, 0, 8'h10 + 8'(k));
        send(1, 1, 8'hC4);
        chk("sat clear err_cnt", int'(uo_out), 8'h00);
        check_all("sat clear");

        // lock latency, five isolated errors, then asynchronous reset and re-hunt
        do_reset();
        send(1, 0, 8'h10);
        send(1, 0, 8'h11);
        send(1, 0, 8'h12);
        cyc(1, 0, 8'h13);
        for (int i = 0; i <= LAT; i++) begin
            chk($sformatf("latency locked +%0d", i), int'(uio_out[2]), int'(i == LAT));
            if (i < LAT) cyc(0, 0, 8'h00);
        end
        e = 8'h14;
        repeat (5) begin
            send(1, 0, e ^ 8'h80);
            e = e + 8'd1;
            send(1, 0, e);
            e = e + 8'd1;
        end
        chk("five err_cnt", int'(uo_out), 8'h05);
        chk("five locked", int'(uio_out[2]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst uo_out", int'(uo_out), 8'h00);
        chk("async rst uio_out", int'(uio_out), 8'h20);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LOCK; k++) send(1, 0, 8'h50 + 8'(k));
        chk("relock locked", int'(uio_out[2]), 1);
        check_all("relock");

        // random stream: mostly in-sequence data, stray values, gaps and clears
        do_reset();
        ctr = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 99) == 0) ctr = 8'($urandom);
            cyc(v, c, ($urandom_range(0, 9) < 7) ? ctr : 8'($urandom));
            if (v) ctr = ctr + 8'd1;
            check_all($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_count_checker.md
TT_UM_COUNT_CHECKER -- requirements
Module: tt_um_count_checker

Interface
REQ-001 SHALL have parameter LOCK_MATCHES, default 4: consecutive matching samples required to declare lock (range 2..15).
REQ-002 SHALL have parameter LOSS_ERRORS, default 3: consecutive mismatches while locked that force loss of lock (range 1..15).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ui_in  input  8  incoming 8-bit incrementing counter stream (sample data).
REQ-006 SHALL have port uio_in  input  8  [0] valid strobe (sample when 1), [1] clear request, [7:2] unused.
REQ-007 SHALL have port uo_out  output  8  saturating mismatch count.
REQ-008 SHALL have port uio_out  output  8  [2] locked, [3] loss_sticky, [4] err_pulse, [5] hunting, [1:0] and [7:6] driven 0.
REQ-009 SHALL have port uio_oe  output  8  constant 8'b1111_1100.
REQ-010 SHALL have port ena  input  1  ignored; all unused inputs SHALL be folded into one unused-signal sink.

Function
REQ-011 SHALL implement a three-state FSM: HUNT, CONFIRM, LOCKED; samples are acted on only in cycles with valid=1.
REQ-012 HUNT + valid: expected <= data+1, match_cnt <= 1, go CONFIRM.
REQ-013 CONFIRM + valid + data==expected: expected <= data+1, match_cnt++; on reaching LOCK_MATCHES go LOCKED, err_run <= 0.
REQ-014 CONFIRM + valid + mismatch: re-seed expected <= data+1, match_cnt <= 1, stay CONFIRM; error counter NOT incremented.
REQ-015 LOCKED + valid + match: expected <= data+1, err_run <= 0.
REQ-016 LOCKED + valid + mismatch: expected <= expected+1 (no re-seed), err_cnt saturating increment, err_run++, err_pulse high one cycle.
REQ-017 LOCKED: when err_run reaches LOSS_ERRORS, go HUNT and set loss_sticky; the mismatch that triggers the loss SHALL still be counted.
REQ-018 All expected arithmetic SHALL be modulo 256: 8'hFF followed by 8'h00 is a match.
REQ-019 err_cnt SHALL saturate at 8'hFF and never wrap.
REQ-020 clear=1 (sampled any cycle, independent of valid) SHALL zero err_cnt and loss_sticky; FSM state unaffected; clear wins over a simultaneous increment or loss event.
REQ-021 All outputs SHALL be registered; response appears on outputs the clk edge after the sample edge (+ synchronizer latency, REQ-026).
REQ-022 locked = (state==LOCKED); hunting = (state==HUNT); CONFIRM shows both 0.
REQ-023 valid=0 cycles SHALL hold all state; gaps between samples never cause errors.

Reset
REQ-024 rst_n low SHALL asynchronously force: state HUNT, expected 0, match_cnt 0, err_run 0, err_cnt 0, loss_sticky 0, err_pulse 0, synchronizer flops 0; hence uo_out=8'h00, uio_out=8'h20.
REQ-025 Reset asserted mid-stream SHALL discard lock; after release the checker re-hunts from the next valid sample.

Configuration
REQ-026 Macro CHK_INPUT_SYNC_EN defined: ui_in, uio_in[0], uio_in[1] pass through a 2-flop synchronizer before use, adding exactly 2 cycles latency; undefined: inputs used directly, no added latency, no synchronizer flops.

Structure
REQ-027 Shared package tt_chk_pkg SHALL hold the FSM state enum (HUNT, CONFIRM, LOCKED), default LOCK_MATCHES/LOSS_ERRORS constants, and uio_out bit-index constants.
REQ-028 One sub-module chk_sync2 (parameterised-width 2-flop synchronizer, async reset) SHALL be instantiated only under CHK_INPUT_SYNC_EN.

Verification
REQ-029 Reset, then valid samples 0x10..0x14 -> locked=1 one cycle after 4th sample (0x13), uo_out=0x00.
REQ-030 Locked, send 0xFE,0xFF,0x00,0x01 -> no err_pulse, uo_out unchanged (wrap match).
REQ-031 Locked at 0x20, send 0x21,0x55,0x23 -> one err_pulse, uo_out=0x01, stays LOCKED (free-run expected realigns).
REQ-032 Locked, send 3 consecutive mismatches -> uo_out +3, hunting=1, loss_sticky=1; clear pulse -> uo_out=0x00, loss_sticky=0.
REQ-033 Force 300 mismatches in lock/relock cycles -> uo_out sticks at 0xFF; clear coincident with mismatch -> uo_out=0x00.
REQ-034 Assert rst_n low while LOCKED with uo_out=0x05 -> immediately uo_out=0x00, uio_out=0x20; run both macro settings, checking +2 cycle latency when CHK_INPUT_SYNC_EN defined.
